// File: rtl/vblank_scheduler.sv
// rtl/vblank_scheduler.sv - round-robin vblank update-access scheduler for game-logic requesters
// Optional per-grant timeout compiled in with `define VBLANK_SCHED_TIMEOUT_EN.
module vblank_scheduler #(
    parameter int N_REQ     = 4,
    parameter int V_VISIBLE = 480,
    parameter int TIMEOUT   = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       y,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int         IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [9:0] VV = 10'(V_VISIBLE);

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    state_t           state, state_n;
    logic [9:0]       y_q;
    logic             vblank_start, vblank_end;
    logic [N_REQ-1:0] served, served_n, gnt_n, elig;
    logic [IW-1:0]    rr_ptr, rr_n, hit_idx;
    logic             hit;
    logic [15:0]      frame_n;
    logic             overrun_n;

    assign vblank_start = (y == VV) && (y_q != VV);
    assign vblank_end   = (y < VV) && (y_q >= VV);
    assign busy         = (state != IDLE);
    assign elig         = req & ~served;

`ifdef VBLANK_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt, wait_cnt_n, wait_inc;
    logic          timeout_hit, timeout_n;

    // Saturating count of cycles spent in the current grant
    assign wait_inc    = (wait_cnt == CW'(TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;
    assign timeout_hit = (wait_inc == CW'(TIMEOUT));
`else
    // Grants are held until done or vblank end; TIMEOUT is inert in this build
    assign timeout_err = (TIMEOUT < 0);
`endif

    // Round-robin search starting just after the last granted index
    always_comb begin
        int j;
        hit     = 1'b0;
        hit_idx = '0;
        j       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!hit && elig[IW'(j)]) begin
                hit     = 1'b1;
                hit_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        served_n  = served;
        rr_n      = rr_ptr;
        frame_n   = frame_count;
        overrun_n = 1'b0;
`ifdef VBLANK_SCHED_TIMEOUT_EN
        wait_cnt_n = wait_cnt;
        timeout_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (vblank_start) begin
                    served_n = '0;
                    frame_n  = frame_count + 16'd1;
                    state_n  = ARB;
                end
            end
            ARB: begin
                if (hit) begin
                    gnt_n          = '0;
                    gnt_n[hit_idx] = 1'b1;
                    rr_n           = hit_idx;
                    state_n        = GRANT;
`ifdef VBLANK_SCHED_TIMEOUT_EN
                    wait_cnt_n     = '0;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
`ifdef VBLANK_SCHED_TIMEOUT_EN
                wait_cnt_n = wait_inc;
`endif
                // done wins over timeout, timeout wins over vblank end
                if (|(done & gnt)) begin
                    served_n = served | gnt;
                    gnt_n    = '0;
                    state_n  = vblank_end ? IDLE : ARB;
                end
`ifdef VBLANK_SCHED_TIMEOUT_EN
                else if (timeout_hit) begin
                    served_n  = served | gnt;
                    gnt_n     = '0;
                    timeout_n = 1'b1;
                    state_n   = ARB;
                end
`endif
                else if (vblank_end) begin
                    gnt_n     = '0;
                    overrun_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= '0;
            served      <= '0;
            rr_ptr      <= IW'(N_REQ - 1);
            frame_count <= 16'd0;
            overrun     <= 1'b0;
            y_q         <= 10'd0;
`ifdef VBLANK_SCHED_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            served      <= served_n;
            rr_ptr      <= rr_n;
            frame_count <= frame_n;
            overrun     <= overrun_n;
            y_q         <= y;
`ifdef VBLANK_SCHED_TIMEOUT_EN
            wait_cnt    <= wait_cnt_n;
            timeout_err <= timeout_n;
`endif
        end
    end

endmodule

// File: tb/tb_vblank_scheduler.sv
// tb/tb_vblank_scheduler.sv - directed scoreboard bench for vblank_scheduler
module tb_vblank_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [9:0]   y = 10'd0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] gnt;
    logic         busy;
    logic [15:0]  frame_count;
    logic         overrun;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int to_cnt = 0;
    int exp_q[$];

    vblank_scheduler #(.N_REQ(N), .V_VISIBLE(480), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .y(y), .req(req), .done(done),
        .gnt(gnt), .busy(busy), .frame_count(frame_count),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (timeout_err === 1'b1) to_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant and compare it with the next scoreboard entry
    task automatic wait_gnt(input string tag, input int budget);
        int n;
        int e;
        logic [31:0] exp_v;
        n = 0;
        while (gnt === '0 && n < budget) begin
            tick();
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        exp_v = (e >= 0) ? (32'd1 << e) : 32'd0;
        check(tag, 32'(gnt), exp_v);
    endtask

    task automatic serve(input string tag);
        repeat (4) tick();
        done = gnt;
        tick();
        done = '0;
        check(tag, 32'(gnt), 32'd0);
    endtask

    // Leaves the DUT in ARB: the grant appears after one more edge
    task automatic start_frame();
        y = 10'd0;
        tick();
        y = 10'd479;
        tick();
        y = 10'd480;
        tick();
    endtask

    initial begin
        int hi;
        repeat (2) tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame", 32'(frame_count), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_to", 32'(timeout_err), 0);
        reset = 1'b0;

        // Frame 1: everyone requests, served 0..3 in order, exact first-grant latency
        req = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        y = 10'd479;
        tick();
        y = 10'd480;
        tick();
        check("lat_gnt_early", 32'(gnt), 0);
        check("f1_busy", 32'(busy), 1);
        check("f1_frame", 32'(frame_count), 1);
        tick();
        wait_gnt("f1_g0", 0);
        serve("f1_r0");
        wait_gnt("f1_g1", 1);
        serve("f1_r1");
        wait_gnt("f1_g2", 1);
        serve("f1_r2");
        wait_gnt("f1_g3", 1);
        serve("f1_r3");
        tick();
        check("f1_idle", 32'(busy), 0);
        check("f1_ovr", 32'(ovr_cnt), 0);
        check("f1_to", 32'(to_cnt), 0);

        // Frame 2: sparse requests, grant held while req toggles
        req = 4'b1010;
        exp_q.push_back(1); exp_q.push_back(3);
        start_frame();
        wait_gnt("f2_g1", 1);
        req = 4'b0000;
        tick();
        tick();
        check("f2_hold", 32'(gnt), 32'b0010);
        req = 4'b1010;
        serve("f2_r1");
        wait_gnt("f2_g3", 1);
        serve("f2_r3");
        tick();
        check("f2_idle", 32'(busy), 0);
        check("f2_frame", 32'(frame_count), 2);

        // Frame 3: foreign done ignored, done together with vblank end
        req = 4'b0001;
        exp_q.push_back(0);
        start_frame();
        wait_gnt("f3_g0", 1);
        done = 4'b0100;
        tick();
        done = '0;
        check("f3_foreign_done", 32'(gnt), 32'b0001);
        y = 10'd0;
        done = 4'b0001;
        tick();
        done = '0;
        check("f3_end_gnt", 32'(gnt), 0);
        check("f3_end_ovr", 32'(overrun), 0);
        check("f3_end_idle", 32'(busy), 0);

        // Frame 4: vblank ends while granted -> overrun
        exp_q.push_back(0);
        start_frame();
        wait_gnt("f4_g0", 1);
        y = 10'd524;
        tick();
        y = 10'd0;
        tick();
        check("f4_ovr_gnt", 32'(gnt), 0);
        check("f4_ovr_pulse", 32'(overrun), 1);
        check("f4_ovr_idle", 32'(busy), 0);
        tick();
        check("f4_ovr_once", 32'(overrun), 0);
        check("f4_ovr_cnt", 32'(ovr_cnt), 1);

        // Frame 5: no done from the granted requester
        exp_q.push_back(0);
        start_frame();
        wait_gnt("f5_g0", 1);
`ifdef VBLANK_SCHED_TIMEOUT_EN
        hi = 0;
        while (gnt !== '0 && hi < 100) begin
            hi++;
            tick();
        end
        check("f5_to_len", 32'(hi), 20);
        check("f5_to_pulse", 32'(timeout_err), 1);
        repeat (10) tick();
        check("f5_no_regrant", 32'(gnt), 0);
        check("f5_idle", 32'(busy), 0);
        check("f5_to_cnt", 32'(to_cnt), 1);
`else
        hi = 0;
        repeat (40) tick();
        check("f5_held", 32'(gnt), 32'b0001);
        check("f5_to_cnt", 32'(to_cnt), 0);
        serve("f5_r0");
`endif

        // Frame 6: reset in the middle of a grant
        req = 4'b0010;
        exp_q.push_back(1);
        start_frame();
        wait_gnt("f6_g1", 1);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_gnt", 32'(gnt), 0);
        check("rst_mid_frame", 32'(frame_count), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ovr", 32'(overrun), 0);
        reset = 1'b0;
        req = 4'b0111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        start_frame();
        wait_gnt("f7_g0", 1);
        serve("f7_r0");
        wait_gnt("f7_g1", 1);
        serve("f7_r1");
        wait_gnt("f7_g2", 1);
        serve("f7_r2");
        check("f7_frame", 32'(frame_count), 1);
        check("end_ovr_cnt", 32'(ovr_cnt), 1);
`ifdef VBLANK_SCHED_TIMEOUT_EN
        check("end_to_cnt", 32'(to_cnt), 1);
`else
        check("end_to_cnt", 32'(to_cnt), 0);
`endif
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vblank_scheduler.md
VBLANK_SCHEDULER -- requirements
Module: vblank_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of game-logic requesters (2..8).
REQ-002 SHALL have parameter V_VISIBLE, default 480, first non-visible line number.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum clk cycles per grant.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port y  input  10  current line from the display timing block.
REQ-007 SHALL have port req  input  N_REQ  per-requester level request for vblank update access.
REQ-008 SHALL have port done  input  N_REQ  per-requester completion pulse, honoured only while that requester is granted.
REQ-009 SHALL have port gnt  output  N_REQ  one-hot-or-zero grant, registered.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port frame_count  output  16  count of vblank starts, wraps 65535->0.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when vblank ends with a grant active.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 SHALL register y into y_q each cycle; vblank_start = (y == V_VISIBLE) and (y_q != V_VISIBLE); vblank_end = (y < V_VISIBLE) and (y_q >= V_VISIBLE).
REQ-015 SHALL implement states IDLE, ARB, GRANT.
REQ-016 IDLE: on vblank_start SHALL clear served mask, increment frame_count, go to ARB next cycle.
REQ-017 ARB: SHALL pick the first index with req=1 and served=0, searching round-robin from rr_ptr+1 (mod N_REQ); on a hit SHALL assert gnt for that index from the next cycle, set rr_ptr to it, go to GRANT; on no hit SHALL go to IDLE.
REQ-018 Latency: gnt SHALL assert exactly 2 cycles after the cycle vblank_start is true when the first eligible requester is already requesting.
REQ-019 GRANT: gnt SHALL stay constant regardless of req changes until done[granted], timeout, or vblank_end.
REQ-020 GRANT: on done[granted] SHALL mark served, clear gnt next cycle, return to ARB.
REQ-021 GRANT: on wait counter reaching TIMEOUT SHALL mark served, clear gnt, pulse timeout_err, return to ARB.
REQ-022 GRANT: on vblank_end without done SHALL clear gnt, pulse overrun, go to IDLE.
REQ-023 Priority in one cycle: done beats timeout beats vblank_end; done with vblank_end SHALL go to IDLE with no overrun.
REQ-024 done on a non-granted index, and vblank_start outside IDLE, SHALL be ignored.
REQ-025 Each requester SHALL receive at most one grant per frame; rr_ptr SHALL persist across frames.
REQ-026 Wait counter SHALL clear on entry to GRANT and saturate, never wrap.

Reset
REQ-027 On reset SHALL set state IDLE, gnt=0, busy=0, frame_count=0, overrun=0, timeout_err=0, served=0, rr_ptr=N_REQ-1, y_q=0, counter=0.
REQ-028 Reset during GRANT SHALL drop gnt at the same clock edge, without an overrun pulse.

Configuration
REQ-029 Macro VBLANK_SCHED_TIMEOUT_EN defined SHALL compile in the wait counter and REQ-021 behaviour.
REQ-030 Without VBLANK_SCHED_TIMEOUT_EN SHALL omit the counter, tie timeout_err to 0, and hold grants until done or vblank_end.

Verification
REQ-031 req=4'b1111, each done 5 cycles after its grant -> grants 0,1,2,3 in order in one vblank; frame_count=1; no error pulses.
REQ-032 Second frame: req=4'b1010 -> grants 1 then 3, then IDLE and busy=0.
REQ-033 Macro defined, TIMEOUT=20, req=4'b0001, no done -> gnt[0] drops after 20 cycles; one timeout_err pulse; no second grant that frame.
REQ-034 Grant active while y goes 524->0, no done -> gnt=0 next cycle; one overrun pulse; state IDLE.
REQ-035 done[2] while gnt=4'b0001, and done[0] with vblank_end in the same cycle -> first ignored; second ends the grant with no overrun.
REQ-036 Reset asserted mid-GRANT -> gnt=0, frame_count=0 after the next edge; next vblank grants index 0 first.
